pifo_cmd_driver: RTL

Synthesizable front end for `PIFO_SRAM_TOP`. Accepts per-lane push/pop commands over valid/ready and drives the PIFO's per-lane `i_push`/`i_pop`/`i_tree_id`/`i_push_data`. It respects `o_task_fifo_full` and tracks per-tree occupancy so the PIFO never sees a push to a full tree or a pop from an empty tree. It also captures `o_pop_data` after the fixed PIFO pop latency and returns it to the requester as a tagged response.

---
 rtl/pifo_pkg.sv | 42 ++++
 rtl/pifo_pop_tracker.sv | 58 +++++
 rtl/pifo_cmd_driver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pifo_pkg: shared types and size derivations for the PIFO command driver.
// Rev 1.0
// ---------------------------------------------------------------------------
package pifo_pkg;

  localparam int DEF_PTW      = 16;
  localparam int DEF_LEVEL    = 4;
  localparam int DEF_TREE_NUM = 4;
  localparam int DEF_POP_LAT  = 2;

  function automatic int tree_bits_f(input int tree_num);
    return $clog2(tree_num);
  endfunction

  // A tree of LEVEL levels holds 2 + 4 + ... + 2**LEVEL entries.
  function automatic int capacity_f(input int level);
    return 2 ** (level + 1) - 2;
  endfunction

  function automatic int occ_w_f(input int capacity);
    return $clog2(capacity + 1);
  endfunction

  localparam int DEF_TREE_NUM_BITS = tree_bits_f(DEF_TREE_NUM);
  localparam int DEF_CAPACITY      = capacity_f(DEF_LEVEL);
  localparam int DEF_OCC_W         = occ_w_f(DEF_CAPACITY);

  typedef struct packed {
    logic                         pop;
    logic [DEF_TREE_NUM_BITS-1:0] tree;
    logic [DEF_PTW-1:0]           data;
  } cmd_t;

  typedef struct packed {
    logic [DEF_TREE_NUM_BITS-1:0] tree;
    logic [DEF_PTW-1:0]           data;
  } rsp_t;

endpackage
`default_nettype wire

// File: rtl/pifo_pop_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pifo_pop_tracker: per-lane pop latency delay line plus response register.
// Rev 1.0
// ---------------------------------------------------------------------------
module pifo_pop_tracker
  import pifo_pkg::*;
#(
  parameter int PTW           = DEF_PTW,
  parameter int TREE_NUM_BITS = DEF_TREE_NUM_BITS,
  parameter int POP_LAT       = DEF_POP_LAT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     pop_i,
  input  logic [TREE_NUM_BITS-1:0] tree_i,
  input  logic [PTW-1:0]           pop_data_i,
  output logic                     rsp_valid_o,
  output rsp_t                     rsp_o
);

  localparam int LAST = POP_LAT - 1;

  logic [POP_LAT-1:0]                    vld_q;
  logic [POP_LAT-1:0][TREE_NUM_BITS-1:0] tree_q;
  logic                                  rsp_vld_q;
  rsp_t                                  rsp_q;

  // Fed from the registered PIFO pop, so the last stage lines up with the
  // cycle in which the PIFO presents its pop data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q     <= '0;
      tree_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      vld_q[0]  <= pop_i;
      tree_q[0] <= tree_i;
      for (int s = 1; s < POP_LAT; s++) begin
        vld_q[s]  <= vld_q[s-1];
        tree_q[s] <= tree_q[s-1];
      end
      rsp_vld_q <= vld_q[LAST];
      if (vld_q[LAST]) begin
        rsp_q.tree <= tree_q[LAST];
        rsp_q.data <= pop_data_i;
      end else begin
        rsp_q <= '0;
      end
    end
  end

  assign rsp_valid_o = rsp_vld_q;
  assign rsp_o       = rsp_q;

endmodule
`default_nettype wire

// File: rtl/pifo_cmd_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pifo_cmd_driver: per-lane push/pop front end for PIFO_SRAM_TOP with
// per-tree occupancy gating and tagged pop responses.  Rev 1.0
// ---------------------------------------------------------------------------
module pifo_cmd_driver
  import pifo_pkg::*;
#(
  parameter int PTW           = DEF_PTW,
  parameter int LEVEL         = DEF_LEVEL,
  parameter int TREE_NUM      = DEF_TREE_NUM,
  parameter int TREE_NUM_BITS = tree_bits_f(TREE_NUM),
  parameter int POP_LAT       = DEF_POP_LAT,
  parameter int CAPACITY      = capacity_f(LEVEL),
  parameter int OCC_W         = occ_w_f(CAPACITY)
) (
  input  logic                                    i_clk,
  input  logic                                    i_arst_n,
  input  logic [LEVEL-1:0]                        i_cmd_valid,
  input  logic [LEVEL-1:0]                        i_cmd_pop,
  input  logic [LEVEL-1:0][TREE_NUM_BITS-1:0]     i_cmd_tree,
  input  logic [LEVEL-1:0][PTW-1:0]               i_cmd_data,
  output logic [LEVEL-1:0]                        o_cmd_ready,
  output logic [LEVEL-1:0]                        o_push,
  output logic [LEVEL-1:0]                        o_pop,
  output logic [LEVEL-1:0][TREE_NUM_BITS-1:0]     o_tree_id,
  output logic [LEVEL-1:0][PTW-1:0]               o_push_data,
  input  logic [LEVEL-1:0]                        i_task_fifo_full,
  input  logic [LEVEL-1:0][PTW-1:0]               i_pop_data,
  output logic [LEVEL-1:0]                        o_rsp_valid,
  output logic [LEVEL-1:0][TREE_NUM_BITS-1:0]     o_rsp_tree,
  output logic [LEVEL-1:0][PTW-1:0]               o_rsp_data,
  output logic [TREE_NUM-1:0][OCC_W-1:0]          o_occ
);

  // Headroom so occupancy plus every lane's push fits without wrapping.
  localparam int CW = OCC_W + $clog2(LEVEL + 1);

  cmd_t [LEVEL-1:0]                    cmd_w;
  logic [LEVEL-1:0]                    grant_w;
  logic [TREE_NUM-1:0][CW-1:0]         push_cnt_w;
  logic [TREE_NUM-1:0][CW-1:0]         pop_cnt_w;
  logic [TREE_NUM-1:0][OCC_W-1:0]      occ_q;
  logic [TREE_NUM-1:0][OCC_W-1:0]      occ_d;
  logic [TREE_NUM-1:0]                 occ_ok_w;

  logic [LEVEL-1:0]                    push_q;
  logic [LEVEL-1:0]                    pop_q;
  logic [LEVEL-1:0][TREE_NUM_BITS-1:0] tree_q;
  logic [LEVEL-1:0][PTW-1:0]           data_q;

  // Lanes are walked in index order; pushes only see earlier pushes and pops
  // only see earlier pops, so a same-cycle push never credits a pop.
  always_comb begin
    cmd_w       = '0;
    push_cnt_w  = '0;
    pop_cnt_w   = '0;
    o_cmd_ready = '0;
    grant_w     = '0;
    for (int j = 0; j < LEVEL; j++) begin
      cmd_w[j].pop  = i_cmd_pop[j];
      cmd_w[j].tree = i_cmd_tree[j];
      cmd_w[j].data = i_cmd_data[j];
      if (i_arst_n && !i_task_fifo_full[j]) begin
        if (cmd_w[j].pop) begin
          o_cmd_ready[j] = CW'(occ_q[cmd_w[j].tree]) > pop_cnt_w[cmd_w[j].tree];
        end else begin
          o_cmd_ready[j] = (CW'(occ_q[cmd_w[j].tree]) + push_cnt_w[cmd_w[j].tree])
                           < CW'(CAPACITY);
        end
      end
      grant_w[j] = i_cmd_valid[j] && o_cmd_ready[j];
      if (grant_w[j]) begin
        if (cmd_w[j].pop) begin
          pop_cnt_w[cmd_w[j].tree] = pop_cnt_w[cmd_w[j].tree] + CW'(1);
        end else begin
          push_cnt_w[cmd_w[j].tree] = push_cnt_w[cmd_w[j].tree] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    logic [CW-1:0] occ_sum;
    occ_sum  = '0;
    occ_d    = '0;
    occ_ok_w = '0;
    for (int t = 0; t < TREE_NUM; t++) begin
      occ_sum     = CW'(occ_q[t]) + push_cnt_w[t] - pop_cnt_w[t];
      occ_ok_w[t] = occ_sum <= CW'(CAPACITY);
      occ_d[t]    = occ_sum[OCC_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      occ_q  <= '0;
      push_q <= '0;
      pop_q  <= '0;
      tree_q <= '0;
      data_q <= '0;
    end else begin
      occ_q <= occ_d;
      for (int j = 0; j < LEVEL; j++) begin
        push_q[j] <= grant_w[j] && !cmd_w[j].pop;
        pop_q[j]  <= grant_w[j] && cmd_w[j].pop;
        tree_q[j] <= grant_w[j] ? cmd_w[j].tree : '0;
        data_q[j] <= (grant_w[j] && !cmd_w[j].pop) ? cmd_w[j].data : '0;
      end
    end
  end

  a_occ_no_wrap: assert property (@(posedge i_clk) disable iff (!i_arst_n) &occ_ok_w);

  assign o_push      = push_q;
  assign o_pop       = pop_q;
  assign o_tree_id   = tree_q;
  assign o_push_data = data_q;
  assign o_occ       = occ_q;

  for (genvar j = 0; j < LEVEL; j++) begin : g_lane
    rsp_t rsp_w;

    pifo_pop_tracker #(
      .PTW           (PTW),
      .TREE_NUM_BITS (TREE_NUM_BITS),
      .POP_LAT       (POP_LAT)
    ) u_trk (
      .clk_i       (i_clk),
      .rst_ni      (i_arst_n),
      .pop_i       (pop_q[j]),
      .tree_i      (tree_q[j]),
      .pop_data_i  (i_pop_data[j]),
      .rsp_valid_o (o_rsp_valid[j]),
      .rsp_o       (rsp_w)
    );

    assign o_rsp_tree[j] = rsp_w.tree;
    assign o_rsp_data[j] = rsp_w.data;
  end

endmodule
`default_nettype wire
